i2s_tri_tx: RTL
===============

Name: i2s_tri_tx

Overview:
- Stereo audio serial transmitter, the consumer end of the triangle-wave ROM path.
- Fetches one left and one right sample word per frame and serialises them MSB-first in I2S format to the external DAC.
- Generates its own bit clock (bclk) and word-select clock (lrck) from the system clock.
- Issues a one-cycle sample_req pulse per frame so the upstream ROM address logic advances.

Parameters:
DATA_W, 8, sample word width in bits
FRAME_BITS, 16, bclk periods per channel slot; must be >= DATA_W+1
BCLK_DIV, 2, system clocks per bclk half-period; must be >= 1

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
en  input  1  level; 1 = run continuous frames
sample_l  input  DATA_W  left-channel sample, must be stable during the sample_req cycle
sample_r  input  DATA_W  right-channel sample, must be stable during the sample_req cycle
sample_req  output  1  one-clk pulse; samples captured in this cycle
bclk  output  1  serial bit clock
lrck  output  1  word select; 0 = left, 1 = right
sdata  output  1  serial data, changes on bclk falling edge
busy  output  1  high while a frame is in progress

Behaviour:
- Reset values (async, rst_n low): all outputs 0, state IDLE, all counters 0, shadow registers 0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and runs only outside IDLE.
  - tick when div_cnt == BCLK_DIV-1; bclk toggles on every tick.
  - fall_tick = tick while bclk == 1.
- States:
  - IDLE: bclk=0, lrck=0, sdata=0, busy=0, div_cnt held at 0. When en=1: capture sample_l/sample_r into shadow regs, pulse sample_req, bit_cnt=0, lrck=0, busy=1, go to RUN. Latency from en rise to first sample_req is 1 clk.
  - RUN: on each fall_tick, bit_cnt increments.
    - At bit_cnt == FRAME_BITS-1, bit_cnt wraps to 0 and lrck toggles.
    - If lrck was 1 (end of right slot) and en=1: recapture samples and pulse sample_req in that same clk.
    - If lrck was 1 and en=0: go to IDLE after that fall_tick, with outputs as listed under IDLE.
- Slot data:
  - In the slot selecting word W (left shadow when lrck=0, right when lrck=1), at slot index k after the fall_tick: sdata = W[DATA_W-k] for 1 <= k <= DATA_W, else 0.
  - This gives the I2S one-bit delay: the MSB appears one bclk after the lrck edge.
- Frame period = 2*FRAME_BITS*2*BCLK_DIV clk; sample_req fires exactly once per frame.
- en deassert mid-frame: the current frame completes in full and no new sample_req is issued. en reassert before the frame ends keeps streaming seamlessly.
- Input stability: sample_l/sample_r changes outside the sample_req cycle have no effect on the frame being sent.
- rst_n assert mid-frame: immediate clear to the reset values. After release the block restarts from IDLE and no partial frame resumes.

Optional Feature:
- Macro I2S_TX_OFFSET_BIN_EN.
- Defined: shadow regs store the samples with the MSB inverted, converting offset-binary ROM data to two's complement (8'h80 sent as 8'h00, 8'hFF as 8'h7F).
- Undefined: samples are sent verbatim.

Decomposition:
- Package i2s_tx_pkg: state enum (IDLE, RUN), default DATA_W/FRAME_BITS/BCLK_DIV constants, elaboration checks for the parameter constraints.
- One sub-module, i2s_bclk_gen: divider, bclk, and tick/fall_tick strobes. Shift/slot logic stays in the top.

Test Plan:
1. Reset then en=1, BCLK_DIV=2, FRAME_BITS=16, sample_l=8'hA5, sample_r=8'h3C -> sample_req 1 clk after en; left slot bits 1..8 = 1,0,1,0,0,1,0,1; right slot bits 1..8 = 0,0,1,1,1,1,0,0; remaining slot bits 0.
2. Continuous en=1 over 4 frames -> sample_req period exactly 128 clk; lrck period 32 bclk; bclk period 4 clk.
3. en dropped at bit 5 of the left slot -> frame completes through right slot bit 15; no further sample_req; outputs return to the IDLE values.
4. rst_n pulsed low at the middle of the right slot -> bclk/lrck/sdata/busy/sample_req all 0 asynchronously; with en high, restart yields sample_req 1 clk after rst_n release.
5. sample_l changed from 8'hFF to 8'h00 one clk after sample_req -> current frame still sends 8'hFF in the left slot.
6. With I2S_TX_OFFSET_BIN_EN, sample_l=8'h80 -> left slot bits 1..8 all 0; without the macro -> 1 followed by seven 0s.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared types, default geometry and parameter legality check for the I2S triangle-wave transmitter.
package i2s_tx_pkg;

  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefFrameBits = 16;
  localparam int unsigned DefBclkDiv   = 2;

  typedef enum logic {
    StIdle,
    StRun
  } tx_state_e;

  // A slot must hold the one-bit I2S delay plus the whole word.
  function automatic bit params_ok(input int unsigned data_w, input int unsigned frame_bits,
                                   input int unsigned bclk_div);
    return (data_w >= 1) && (frame_bits >= data_w + 1) && (bclk_div >= 1);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk_i down to bclk and flags the cycle ending each bclk-high phase.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic run_i,
  output logic bclk_o,
  output logic fall_tick_o
);

  localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(BCLK_DIV - 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            bclk_q, bclk_d;
  logic            tick;

  always_comb begin
    tick      = run_i && (div_cnt_q == DivMax);
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!run_i) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (tick) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DivW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o      = bclk_q;
  assign fall_tick_o = tick && bclk_q;

endmodule

// File: rtl/i2s_tri_tx.sv
// Stereo I2S transmitter: fetches one L/R pair per frame and shifts it MSB-first to the DAC.
// Define I2S_TX_OFFSET_BIN_EN to convert offset-binary samples to two's complement on capture.
module i2s_tri_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned FRAME_BITS = DefFrameBits,
  parameter int unsigned BCLK_DIV   = DefBclkDiv
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] sample_l_i,
  input  logic [DATA_W-1:0] sample_r_i,
  output logic              sample_req_o,
  output logic              bclk_o,
  output logic              lrck_o,
  output logic              sdata_o,
  output logic              busy_o
);

  if (!params_ok(DATA_W, FRAME_BITS, BCLK_DIV)) begin : g_bad_params
    $error("i2s_tri_tx: FRAME_BITS must be >= DATA_W+1 and BCLK_DIV >= 1");
  end

  localparam int unsigned BitW = $clog2(FRAME_BITS);
  localparam logic [BitW-1:0] SlotLast = BitW'(FRAME_BITS - 1);
  localparam logic [DATA_W-1:0] MsbMask = DATA_W'(1) << (DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              lrck_q, lrck_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] shadow_l_q, shadow_l_d;
  logic [DATA_W-1:0] shadow_r_q, shadow_r_d;
  logic [DATA_W-1:0] conv_mask, word, word_shifted;
  logic              fall_tick, in_data;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .run_i       (state_q == StRun),
    .bclk_o      (bclk_o),
    .fall_tick_o (fall_tick)
  );

`ifdef I2S_TX_OFFSET_BIN_EN
  assign conv_mask = MsbMask;
`else
  assign conv_mask = '0;
`endif

  // Samples are latched at the end of the sample_req cycle, while upstream holds them stable.
  always_comb begin
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    if (req_q) begin
      shadow_l_d = sample_l_i ^ conv_mask;
      shadow_r_d = sample_r_i ^ conv_mask;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    req_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        lrck_d    = 1'b0;
        if (en_i) begin
          req_d   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (fall_tick) begin
          if (bit_cnt_q == SlotLast) begin
            bit_cnt_d = '0;
            lrck_d    = ~lrck_q;
            if (lrck_q) begin
              if (en_i) begin
                req_d = 1'b1;
              end else begin
                state_d = StIdle;
                lrck_d  = 1'b0;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      lrck_q     <= 1'b0;
      req_q      <= 1'b0;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      req_q      <= req_d;
      shadow_l_q <= shadow_l_d;
      shadow_r_q <= shadow_r_d;
    end
  end

  // Slot index 0 is the I2S delay bit; indices 1..DATA_W carry the word MSB-first.
  always_comb begin
    word         = lrck_q ? shadow_r_q : shadow_l_q;
    word_shifted = word << (bit_cnt_q - BitW'(1));
    in_data      = (bit_cnt_q != '0) && (bit_cnt_q <= BitW'(DATA_W));
    sdata_o      = in_data && word_shifted[DATA_W-1];
  end

  assign sample_req_o = req_q;
  assign lrck_o       = lrck_q;
  assign busy_o       = (state_q == StRun);

endmodule
